icache_refill_ctrl: RTL and testbench
=====================================

# icache_refill_ctrl

Direct-mapped instruction cache with miss-refill controller on the fetch path. It produces the `stall` signal that freezes the fetch-stage PC register while a line is refilled from instruction memory over a word-per-beat req/ack handshake. It returns instruction words to the decode stage on hits and exposes a whole-cache invalidate for `fence.i`.

## Interface
Parameters:
- `LINES`, 16: number of cache lines; must be a power of two, at least 2.
- `WORDS`, 4: 32-bit words per line; must be a power of two, at least 2.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `pc`  in  32: fetch address; bits [1:0] are ignored.
- `fetch_req`  in  1: a fetch is requested this cycle.
- `flush`  in  1: invalidate all lines (`fence.i`).
- `instr`  out  32: instruction word for `pc`.
- `instr_valid`  out  1: `instr` is valid this cycle.
- `stall`  out  1: high holds the PC register (drives its enable input; high = hold).
- `mem_req`  out  1: request one memory word.
- `mem_addr`  out  32: word address of the request; bits [1:0] are always 0.
- `mem_ack`  in  1: memory has returned `mem_rdata` for the current request.
- `mem_rdata`  in  32: memory read data.

## Operation
- Address split: offset = bits [1+log2(WORDS):2]; index = next log2(LINES) bits; tag = the remaining upper bits.
- Storage: a valid bit and a tag per line, plus a data array of LINES×WORDS words.
- Hit: `valid[index]` and a tag match.
- FSM states: IDLE and REFILL.
- IDLE behaviour:
  - `instr_valid` = `fetch_req` & hit, combinational.
  - `instr` = the addressed data word.
  - `stall` = `fetch_req` & ~hit.
  - On a miss, latch the line base address into `miss_addr` and go to REFILL.
- REFILL behaviour:
  - `stall` = 1, `instr_valid` = 0, `mem_req` = 1.
  - `mem_addr` = `miss_addr` + 4×beat.
  - On `mem_ack`: write `mem_rdata` into word[beat] and increment beat.
  - On `mem_ack` with beat = WORDS−1: write the tag, set the valid bit, clear beat, return to IDLE.
- The requester must hold `pc` stable while `stall` is high, so the retried fetch hits.
- Handshake rules:
  - `mem_req` and `mem_addr` stay stable until `mem_ack`.
  - `mem_ack` is sampled only while `mem_req` is high; an ack outside REFILL is ignored.
  - Back-to-back acks on consecutive cycles are legal.
- Flush:
  - In IDLE, `flush` clears all valid bits at the next edge.
  - `flush` takes priority over a same-cycle hit: `instr_valid` = 0 and `stall` = 1 for that cycle.
  - In REFILL, `flush` is recorded in a pending bit. The refill completes, but the line is not marked valid, and all valid bits are cleared on completion.
- Reset (also when asserted mid-refill):
  - State → IDLE; `mem_req`, `stall`, `instr_valid` = 0; `instr` = 0.
  - All valid bits, beat and the pending flag are cleared.
  - Data and tag contents are don't-care.

## Timing
- Hit latency: 0 cycles, combinational from `pc`.
- Miss penalty: 1 cycle (detection) + sum of per-beat ack latencies + 1 cycle (retry hit).
- Minimum penalty with `mem_ack` always high is WORDS+1 stall cycles.
- `stall` asserts in the same cycle as the miss and deasserts in the cycle after the last ack.
- All state updates happen on the rising edge of `clk`. `rst` acts immediately, without waiting for a clock edge.

## Configuration
- `ICACHE_PERF_EN` defined:
  - Adds outputs `hit_cnt` [31:0] and `miss_cnt` [31:0].
  - Each increments once per IDLE cycle with `fetch_req` on hit or miss respectively.
  - Both wrap at 2^32 and reset to 0.
- Not defined: those ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Package `icache_pkg`: the state enum (IDLE, REFILL) and localparam functions for the offset, index and tag widths.
- Sub-module `icache_data_ram`: the LINES×WORDS×32 array with a combinational read and a single synchronous write port. Tags and valid bits stay in the top level.

## Test plan
- Cold miss at `pc`=0x100 with `mem_ack` tied to 1:
  - `stall` is high for 5 cycles (WORDS=4).
  - `mem_addr` sequence is 0x100, 0x104, 0x108, 0x10C.
  - The retry returns the word at 0x100 with `instr_valid`=1.
- Sequential hits at 0x104, 0x108 and 0x10C after the refill: 0 stall cycles, data matches memory.
- Conflict at 0x200 (same index, different tag) with a 3-cycle ack delay per beat:
  - `mem_req` and `mem_addr` are held during each delay.
  - 0x200 then hits; 0x100 misses again.
- `flush` asserted mid-refill at beat 2:
  - The refill completes.
  - The next fetch of the same address misses and starts a new refill.
- `rst` driven low during beat 1:
  - `mem_req`, `stall`, `instr_valid`, `instr` and beat clear immediately, without waiting for a clock edge.
  - The previously valid line at 0x100 misses after reset.
- With `ICACHE_PERF_EN`: the sequence miss, 3 hits, flush, miss gives `hit_cnt`=3 and `miss_cnt`=2.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-split width helpers for the instruction cache.
package icache_pkg;

  typedef enum logic {StIdle, StRefill} state_e;

  function automatic int unsigned off_w(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned lines, input int unsigned words);
    return 30 - $clog2(lines) - $clog2(words);
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// LINES x WORDS x 32 data array: combinational read, one synchronous write port.
module icache_data_ram
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4,
  localparam int unsigned IW = idx_w(LINES),
  localparam int unsigned OW = off_w(WORDS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [IW-1:0] i_widx,
  input  logic [OW-1:0] i_woff,
  input  logic [31:0]   i_wdata,
  input  logic [IW-1:0] i_ridx,
  input  logic [OW-1:0] i_roff,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [LINES*WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[{i_widx, i_woff}] <= i_wdata;
  end

  assign o_rdata = r_mem[{i_ridx, i_roff}];

endmodule

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped I-cache with word-per-beat miss refill and fence.i flush.
// Optional hit/miss counters when ICACHE_PERF_EN is defined.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc,
  input  logic        i_fetch_req,
  input  logic        i_flush,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  output logic        o_stall,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] o_hit_cnt,
  output logic [31:0] o_miss_cnt
`endif
);

  localparam int unsigned OW = off_w(WORDS);
  localparam int unsigned IW = idx_w(LINES);
  localparam int unsigned TW = tag_w(LINES, WORDS);
  localparam int unsigned LW = 30 - OW;
  localparam logic [OW-1:0] LAST_BEAT = OW'(WORDS - 1);

  state_e          r_state, w_state_nxt;
  logic [OW-1:0]   r_beat;
  logic            r_pend;
  logic [LINES-1:0] r_valid;
  logic [TW-1:0]   r_tag [LINES];
  logic [LW-1:0]   r_miss_line;

  logic [OW-1:0] w_off;
  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic [IW-1:0] w_fill_idx;
  logic [TW-1:0] w_fill_tag;
  logic [31:0]   w_rdata;
  logic          w_hit, w_ack, w_last, w_done, w_miss_start;
  logic          w_instr_valid, w_stall, w_mem_req;
  logic          w_unused_pc;

  assign w_off       = i_pc[OW+1:2];
  assign w_idx       = i_pc[OW+IW+1:OW+2];
  assign w_tag       = i_pc[31:OW+IW+2];
  assign w_unused_pc = ^i_pc[1:0];
  assign w_fill_idx  = r_miss_line[IW-1:0];
  assign w_fill_tag  = r_miss_line[LW-1:IW];

  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_ack  = (r_state == StRefill) && i_mem_ack;
  assign w_last = (r_beat == LAST_BEAT);
  assign w_done = w_ack && w_last;

  always_comb begin
    w_state_nxt   = r_state;
    w_instr_valid = 1'b0;
    w_stall       = 1'b0;
    w_mem_req     = 1'b0;
    unique case (r_state)
      StIdle: begin
        // A flush wins over a same-cycle hit; the fetch retries next cycle.
        w_instr_valid = i_fetch_req && w_hit && !i_flush;
        w_stall       = i_fetch_req && (i_flush || !w_hit);
        if (i_fetch_req && !w_hit && !i_flush) w_state_nxt = StRefill;
      end
      StRefill: begin
        w_stall   = 1'b1;
        w_mem_req = 1'b1;
        if (w_done) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_miss_start = (r_state == StIdle) && (w_state_nxt == StRefill);

  // Outputs are forced low while reset is held, independent of array contents.
  assign o_instr_valid = i_rst_n && w_instr_valid;
  assign o_stall       = i_rst_n && w_stall;
  assign o_mem_req     = i_rst_n && w_mem_req;
  assign o_instr       = i_rst_n ? w_rdata : 32'h0;
  assign o_mem_addr    = {r_miss_line, r_beat, 2'b00};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_beat      <= '0;
      r_pend      <= 1'b0;
      r_valid     <= '0;
      r_miss_line <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_miss_start) r_miss_line <= i_pc[31:OW+2];
      if (r_state == StIdle && i_flush) r_valid <= '0;
      if (w_ack) r_beat <= w_last ? '0 : r_beat + 1'b1;
      if (w_done) begin
        if (r_pend || i_flush) begin
          r_valid <= '0;
          r_pend  <= 1'b0;
        end else begin
          r_valid[w_fill_idx] <= 1'b1;
        end
      end else if (r_state == StRefill && i_flush) begin
        r_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_done) r_tag[w_fill_idx] <= w_fill_tag;
  end

  icache_data_ram #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_data_ram (
    .i_clk   (i_clk),
    .i_we    (w_ack),
    .i_widx  (w_fill_idx),
    .i_woff  (r_beat),
    .i_wdata (i_mem_rdata),
    .i_ridx  (w_idx),
    .i_roff  (w_off),
    .o_rdata (w_rdata)
  );

`ifdef ICACHE_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else if (r_state == StIdle && i_fetch_req) begin
      if (w_hit) o_hit_cnt <= o_hit_cnt + 32'd1;
      else       o_miss_cnt <= o_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl with a delayed-ack memory model.
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        fetch_req;
  logic        flush;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int total = 0;
  int bad = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  bit prev_wait = 0;
  logic [31:0] prev_addr = 32'h0;
  int hold_viol = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_exp[$];

  always #5 clk = ~clk;

  icache_refill_ctrl #(
    .LINES (16),
    .WORDS (4)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_pc          (pc),
    .i_fetch_req   (fetch_req),
    .i_flush       (flush),
    .o_instr       (instr),
    .o_instr_valid (instr_valid),
    .o_stall       (stall),
    .o_mem_req     (mem_req),
    .o_mem_addr    (mem_addr),
    .i_mem_ack     (mem_ack),
    .i_mem_rdata   (mem_rdata)
`ifdef ICACHE_PERF_EN
    ,
    .o_hit_cnt     (hit_cnt),
    .o_miss_cnt    (miss_cnt)
`endif
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory responder: acks after ack_delay idle cycles, logs every acked address.
  always @(negedge clk) begin
    if (mem_req) begin
      if (prev_wait && mem_addr !== prev_addr) hold_viol++;
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_f(mem_addr);
        q_addr.push_back(mem_addr);
        wait_cnt  = 0;
        prev_wait = 0;
      end else begin
        mem_ack   = 1'b0;
        wait_cnt++;
        prev_wait = 1;
        prev_addr = mem_addr;
      end
    end else begin
      if (prev_wait && rst_n) hold_viol++;
      mem_ack   = 1'b0;
      wait_cnt  = 0;
      prev_wait = 0;
    end
  end

  task automatic do_fetch(input logic [31:0] a, output int stalls);
    logic [31:0] exp;
    bit done;
    pc = a;
    fetch_req = 1'b1;
    q_exp.push_back(mem_f(a));
    stalls = 0;
    done = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (instr_valid) begin
        exp = q_exp.pop_front();
        total++;
        if (instr !== exp) begin
          bad++;
          $display("FAIL fetch_data pc=%h got=%h exp=%h", a, instr, exp);
        end
        done = 1;
        break;
      end
      if (stall) stalls++;
      @(posedge clk); #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout pc=%h got=no_valid exp=valid", a);
      void'(q_exp.pop_front());
    end
    @(posedge clk); #1;
    fetch_req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    pc = 32'h100;
    fetch_req = 1'b1;
    flush = 1'b0;
    #3;
    total += 4;
    if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr); end
    fetch_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_cold_miss;
    int s;
    ack_delay = 0;
    q_addr.delete();
    do_fetch(32'h100, s);
    total += 2;
    if (s != 5) begin bad++; $display("FAIL cold_stall got=%0d exp=5", s); end
    if (q_addr.size() != 4) begin
      bad++; $display("FAIL cold_beats got=%0d exp=4", q_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (q_addr[i] !== 32'h100 + 32'(4 * i)) begin
          bad++; $display("FAIL cold_addr%0d got=%h exp=%h", i, q_addr[i], 32'h100 + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_seq_hits;
    int s;
    for (int i = 1; i < 4; i++) begin
      do_fetch(32'h100 + 32'(4 * i), s);
      total++;
      if (s != 0) begin bad++; $display("FAIL hit_stall%0d got=%0d exp=0", i, s); end
    end
  endtask

  task automatic test_conflict;
    int s;
    int v0;
    ack_delay = 3;
    v0 = hold_viol;
    do_fetch(32'h200, s);
    total += 2;
    if (s != 17) begin bad++; $display("FAIL conflict_stall got=%0d exp=17", s); end
    if (hold_viol != v0) begin bad++; $display("FAIL conflict_hold got=%0d exp=%0d", hold_viol, v0); end
    do_fetch(32'h200, s);
    total++;
    if (s != 0) begin bad++; $display("FAIL conflict_hit got=%0d exp=0", s); end
    ack_delay = 0;
    do_fetch(32'h100, s);
    total++;
    if (s != 5) begin bad++; $display("FAIL conflict_remiss got=%0d exp=5", s); end
  endtask

  task automatic test_flush_mid_refill;
    logic [31:0] exp;
    int stalls;
    bit done;
    bit flushed;
    ack_delay = 0;
    q_addr.delete();
    pc = 32'h300;
    fetch_req = 1'b1;
    q_exp.push_back(mem_f(32'h300));
    stalls = 0;
    done = 0;
    flushed = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (instr_valid) begin
        exp = q_exp.pop_front();
        total++;
        if (instr !== exp) begin bad++; $display("FAIL flush_data got=%h exp=%h", instr, exp); end
        done = 1;
        break;
      end
      if (stall) stalls++;
      @(posedge clk); #1;
      flush = 1'b0;
      if (!flushed && q_addr.size() == 2) begin
        flush = 1'b1;
        flushed = 1;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL flush_timeout got=no_valid exp=valid");
      void'(q_exp.pop_front());
    end
    @(posedge clk); #1;
    fetch_req = 1'b0;
    total += 2;
    if (q_addr.size() != 8) begin bad++; $display("FAIL flush_refills got=%0d exp=8", q_addr.size()); end
    if (stalls != 10) begin bad++; $display("FAIL flush_stall got=%0d exp=10", stalls); end
  endtask

  task automatic test_flush_idle;
    int s;
    pc = 32'h300;
    fetch_req = 1'b1;
    flush = 1'b1;
    @(negedge clk); #1;
    total += 2;
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL flush_idle_valid got=%b exp=0", instr_valid); end
    if (stall !== 1'b1) begin bad++; $display("FAIL flush_idle_stall got=%b exp=1", stall); end
    @(posedge clk); #1;
    flush = 1'b0;
    do_fetch(32'h300, s);
    total++;
    if (s != 5) begin bad++; $display("FAIL flush_idle_miss got=%0d exp=5", s); end
  endtask

  task automatic test_reset_mid_refill;
    int s;
    ack_delay = 0;
    do_fetch(32'h100, s);
    q_addr.delete();
    pc = 32'h140;
    fetch_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (q_addr.size() == 1) break;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total += 4;
    if (mem_req !== 1'b0) begin bad++; $display("FAIL midrst_mem_req got=%b exp=0", mem_req); end
    if (stall !== 1'b0) begin bad++; $display("FAIL midrst_stall got=%b exp=0", stall); end
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", instr_valid); end
    if (instr !== 32'h0) begin bad++; $display("FAIL midrst_instr got=%h exp=0", instr); end
    fetch_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    q_addr.delete();
    do_fetch(32'h140, s);
    total += 2;
    if (s != 5) begin bad++; $display("FAIL midrst_refill got=%0d exp=5", s); end
    if (q_addr.size() == 0 || q_addr[0] !== 32'h140) begin
      bad++; $display("FAIL midrst_beat0 got=%h exp=00000140", q_addr.size() ? q_addr[0] : 32'hx);
    end
    do_fetch(32'h100, s);
    total++;
    if (s != 5) begin bad++; $display("FAIL midrst_cleared got=%0d exp=5", s); end
  endtask

`ifdef ICACHE_PERF_EN
  task automatic test_perf;
    int s;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_fetch(32'h100, s);  // miss, then the retry is the first hit
    do_fetch(32'h104, s);
    do_fetch(32'h108, s);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    pc = 32'h100;
    fetch_req = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (!stall) break;
    end
    total += 2;
    if (hit_cnt !== 32'd3) begin bad++; $display("FAIL perf_hit got=%0d exp=3", hit_cnt); end
    if (miss_cnt !== 32'd2) begin bad++; $display("FAIL perf_miss got=%0d exp=2", miss_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_seq_hits();
    test_conflict();
    test_flush_mid_refill();
    test_flush_idle();
    test_reset_mid_refill();
`ifdef ICACHE_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
